// File: rtl/datapath_pkg.sv
// Shared types for the datapath command sequencer: ALU op codes,
// sequencer FSM states and the queued command record.
package datapath_pkg;

   localparam int unsigned REG_ADDR_W = 2;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOR = 3'b101,
      ALU_SLT = 3'b110,
      ALU_SLL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_HALT   = 2'd3
   } state_e;

   typedef struct packed {
      alu_op_e               op;
      logic [REG_ADDR_W-1:0] a1;
      logic [REG_ADDR_W-1:0] a2;
      logic [REG_ADDR_W-1:0] a3;
      logic                  wr;
      logic                  trap;
   } cmd_t;

   // Assemble a command record from the raw command bus fields.
   function automatic cmd_t make_cmd(
      input logic [2:0]            op,
      input logic [REG_ADDR_W-1:0] a1,
      input logic [REG_ADDR_W-1:0] a2,
      input logic [REG_ADDR_W-1:0] a3,
      input logic                  wr,
      input logic                  trap
   );
      cmd_t c;
      c.op   = alu_op_e'(op);
      c.a1   = a1;
      c.a2   = a2;
      c.a3   = a3;
      c.wr   = wr;
      c.trap = trap;
      return c;
   endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Command input and datapath control/status bus of the sequencer.
// master = command source plus datapath; slave = the sequencer.
interface datapath_seq_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_a1;
   logic [1:0] cmd_a2;
   logic [1:0] cmd_a3;
   logic       cmd_wr;
   logic       cmd_trap;

   logic       dp_wr;
   logic [2:0] dp_alu_ctl;
   logic [1:0] dp_addr1;
   logic [1:0] dp_addr2;
   logic [1:0] dp_addr3;
   logic       dp_zero;
   logic       dp_ovf;

   modport master (
      output cmd_valid, cmd_op, cmd_a1, cmd_a2, cmd_a3, cmd_wr, cmd_trap,
      output dp_zero, dp_ovf,
      input  cmd_ready, dp_wr, dp_alu_ctl, dp_addr1, dp_addr2, dp_addr3
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a1, cmd_a2, cmd_a3, cmd_wr, cmd_trap,
      input  dp_zero, dp_ovf,
      output cmd_ready, dp_wr, dp_alu_ctl, dp_addr1, dp_addr2, dp_addr3
   );

endinterface

// File: rtl/datapath_seq_cmd_fifo.sv
// Synchronous show-ahead command queue. Push is ignored when full and
// pop is ignored when empty; status comes from registered occupancy.
module cmd_fifo
   import datapath_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  cmd_t                   din,
   output cmd_t                   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned    PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   cmd_t             mem_q [DEPTH];
   cmd_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_en    = push & ~full;
      rd_en    = pop & ~empty;
      if (wr_en) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue registers; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/datapath_seq.sv
// Datapath command sequencer: queues ALU commands and drives them into
// the datapath as an EXEC cycle followed by a COMMIT (write) cycle,
// capturing Zero/Overflow and halting on trapped overflows.
module datapath_seq
   import datapath_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   datapath_seq_if.slave    bus,
   input  logic             clr_halt,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic             zero_flag,
   output logic             ovf_flag,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] issued_cnt
);

   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

   cmd_t              fifo_din;
   cmd_t              fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [FCNT_W-1:0] fifo_count;

   state_e            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic              dp_wr_q, dp_wr_d;
   logic              done_q, done_d;
   logic              halted_q, halted_d;
   logic              zero_flag_q, zero_flag_d;
   logic              ovf_flag_q, ovf_flag_d;
   logic              ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;

   assign fifo_din = make_cmd(bus.cmd_op, bus.cmd_a1, bus.cmd_a2, bus.cmd_a3,
                              bus.cmd_wr, bus.cmd_trap);

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.cmd_ready  = ~fifo_full;
   assign bus.dp_wr      = dp_wr_q;
   assign bus.dp_alu_ctl = cmd_q.op;
   assign bus.dp_addr1   = cmd_q.a1;
   assign bus.dp_addr2   = cmd_q.a2;
   assign bus.dp_addr3   = cmd_q.a3;

   assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);
   assign done       = done_q;
   assign halted     = halted_q;
   assign zero_flag  = zero_flag_q;
   assign ovf_flag   = ovf_flag_q;
   assign ovf_sticky = ovf_sticky_q;
   assign issued_cnt = issued_cnt_q;

   // Sequencer next-state; outputs are decoded from the next state so they
   // leave the flops aligned with the state they belong to.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      fifo_pop     = 1'b0;
      zero_flag_d  = zero_flag_q;
      ovf_flag_d   = ovf_flag_q;
      ovf_sticky_d = ovf_sticky_q;
      issued_cnt_d = issued_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            zero_flag_d = bus.dp_zero;
            ovf_flag_d  = bus.dp_ovf;
            if (bus.dp_ovf) begin
               ovf_sticky_d = 1'b1;
            end
            if (cmd_q.trap && bus.dp_ovf) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = ST_EXEC;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (clr_halt) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      dp_wr_d  = (state_d == ST_COMMIT) && cmd_q.wr;
      done_d   = (state_d == ST_COMMIT);
      halted_d = (state_d == ST_HALT);
   end

   // Sequencer registers; reset overrides push, pop and clr_halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         dp_wr_q      <= 1'b0;
         done_q       <= 1'b0;
         halted_q     <= 1'b0;
         zero_flag_q  <= 1'b0;
         ovf_flag_q   <= 1'b0;
         ovf_sticky_q <= 1'b0;
         issued_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         dp_wr_q      <= dp_wr_d;
         done_q       <= done_d;
         halted_q     <= halted_d;
         zero_flag_q  <= zero_flag_d;
         ovf_flag_q   <= ovf_flag_d;
         ovf_sticky_q <= ovf_sticky_d;
         issued_cnt_q <= issued_cnt_d;
      end
   end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: table of single-command vectors plus
// hand-written trap, queue-full, reset-in-COMMIT and counter-wrap sequences.
module tb_datapath_seq;
   import datapath_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr_halt;
   logic          busy, done, halted, zero_flag, ovf_flag, ovf_sticky;
   logic [CW-1:0] issued_cnt;

   datapath_seq_if bus();

   datapath_seq #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clr_halt   (clr_halt),
      .busy       (busy),
      .done       (done),
      .halted     (halted),
      .zero_flag  (zero_flag),
      .ovf_flag   (ovf_flag),
      .ovf_sticky (ovf_sticky),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      cmd_t cmd;
      logic zero;
      logic ovf;
      logic exp_wr;
      logic exp_zf;
      logic exp_of;
      logic exp_sticky;
   } vec_t;

   vec_t vecs [6];
   cmd_t qcmd [4];
   cmd_t c;
   int   exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input cmd_t cm);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = cm.op;
      bus.cmd_a1    = cm.a1;
      bus.cmd_a2    = cm.a2;
      bus.cmd_a3    = cm.a3;
      bus.cmd_wr    = cm.wr;
      bus.cmd_trap  = cm.trap;
   endtask

   // Offer a command across one rising edge; returns at the next negedge.
   task automatic push(input cmd_t cm);
      drive_cmd(cm);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      clr_halt      = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a1    = '0;
      bus.cmd_a2    = '0;
      bus.cmd_a3    = '0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_trap  = 1'b0;
      bus.dp_zero   = 1'b0;
      bus.dp_ovf    = 1'b0;

      vecs[0] = '{'{op: ALU_ADD, a1: 2'd3, a2: 2'd3, a3: 2'd1, wr: 1'b1, trap: 1'b0}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{'{op: ALU_SUB, a1: 2'd1, a2: 2'd1, a3: 2'd1, wr: 1'b1, trap: 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{'{op: ALU_AND, a1: 2'd2, a2: 2'd0, a3: 2'd3, wr: 1'b0, trap: 1'b0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{'{op: ALU_OR,  a1: 2'd0, a2: 2'd1, a3: 2'd2, wr: 1'b1, trap: 1'b0}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{'{op: ALU_XOR, a1: 2'd3, a2: 2'd2, a3: 2'd0, wr: 1'b1, trap: 1'b0}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{'{op: ALU_SLT, a1: 2'd1, a2: 2'd2, a3: 2'd3, wr: 1'b1, trap: 1'b1}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      qcmd[0] = '{op: ALU_ADD, a1: 2'd0, a2: 2'd1, a3: 2'd0, wr: 1'b1, trap: 1'b0};
      qcmd[1] = '{op: ALU_SUB, a1: 2'd1, a2: 2'd2, a3: 2'd1, wr: 1'b1, trap: 1'b0};
      qcmd[2] = '{op: ALU_OR,  a1: 2'd2, a2: 2'd3, a3: 2'd2, wr: 1'b1, trap: 1'b0};
      qcmd[3] = '{op: ALU_XOR, a1: 2'd3, a2: 2'd0, a3: 2'd3, wr: 1'b1, trap: 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_dp_wr", 32'(bus.dp_wr), 32'd0);
      check("rst_flags", 32'({zero_flag, ovf_flag, ovf_sticky}), 32'd0);
      check("rst_cnt", 32'(issued_cnt), 32'd0);

      // Single-command vectors: EXEC at k+2, COMMIT at k+3
      exp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].cmd);
         bus.cmd_valid = 1'b0;
         check("c1_dp_wr", 32'(bus.dp_wr), 32'd0);
         check("c1_busy", 32'(busy), 32'd1);
         @(negedge clk);
         check("exec_alu", 32'(bus.dp_alu_ctl), 32'(vecs[i].cmd.op));
         check("exec_addr", 32'({bus.dp_addr1, bus.dp_addr2, bus.dp_addr3}),
               32'({vecs[i].cmd.a1, vecs[i].cmd.a2, vecs[i].cmd.a3}));
         check("exec_dp_wr", 32'(bus.dp_wr), 32'd0);
         check("exec_done", 32'(done), 32'd0);
         bus.dp_zero = vecs[i].zero;
         bus.dp_ovf  = vecs[i].ovf;
         @(negedge clk);
         check("commit_dp_wr", 32'(bus.dp_wr), 32'(vecs[i].exp_wr));
         check("commit_done", 32'(done), 32'd1);
         check("commit_halted", 32'(halted), 32'd0);
         check("commit_zf", 32'(zero_flag), 32'(vecs[i].exp_zf));
         check("commit_of", 32'(ovf_flag), 32'(vecs[i].exp_of));
         check("commit_sticky", 32'(ovf_sticky), 32'(vecs[i].exp_sticky));
         check("commit_addr3", 32'(bus.dp_addr3), 32'(vecs[i].cmd.a3));
         check("commit_cnt", 32'(issued_cnt), 32'(exp_cnt));
         bus.dp_zero = 1'b0;
         bus.dp_ovf  = 1'b0;
         exp_cnt++;
         @(negedge clk);
         check("post_dp_wr", 32'(bus.dp_wr), 32'd0);
         check("post_done", 32'(done), 32'd0);
         check("post_busy", 32'(busy), 32'd0);
         check("post_cnt", 32'(issued_cnt), 32'(exp_cnt));
      end

      // Reset clears sticky/counter; then trapped overflow halts
      do_reset();
      check("rst2_sticky", 32'(ovf_sticky), 32'd0);
      check("rst2_cnt", 32'(issued_cnt), 32'd0);
      c = '{op: ALU_SUB, a1: 2'd1, a2: 2'd1, a3: 2'd1, wr: 1'b1, trap: 1'b1};
      push(c);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      bus.dp_ovf = 1'b1;
      @(negedge clk);
      bus.dp_ovf = 1'b0;
      check("trap_halted", 32'(halted), 32'd1);
      check("trap_dp_wr", 32'(bus.dp_wr), 32'd0);
      check("trap_done", 32'(done), 32'd0);
      check("trap_sticky", 32'(ovf_sticky), 32'd1);
      check("trap_of", 32'(ovf_flag), 32'd1);
      @(negedge clk);
      check("trap_cnt", 32'(issued_cnt), 32'd0);
      check("trap_hold", 32'({halted, bus.dp_wr, busy}), 32'b101);

      // Fill queue while halted; 5th push ignored
      for (int k = 0; k < 4; k++) begin
         push(qcmd[k]);
      end
      check("full_ready", 32'(bus.cmd_ready), 32'd0);
      c = '{op: ALU_NOR, a1: 2'd2, a2: 2'd2, a3: 2'd2, wr: 1'b0, trap: 1'b0};
      push(c);
      bus.cmd_valid = 1'b0;
      check("full_ready2", 32'(bus.cmd_ready), 32'd0);
      check("full_halted", 32'(halted), 32'd1);
      clr_halt = 1'b1;
      @(negedge clk);
      clr_halt = 1'b0;
      check("clr_halted", 32'(halted), 32'd0);
      check("clr_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("drain_exec_wr", 32'(bus.dp_wr), 32'd0);
         check("drain_exec_alu", 32'(bus.dp_alu_ctl), 32'(qcmd[k].op));
         @(negedge clk);
         check("drain_commit_wr", 32'(bus.dp_wr), 32'd1);
         check("drain_commit_done", 32'(done), 32'd1);
         check("drain_commit_addr", 32'({bus.dp_addr1, bus.dp_addr2, bus.dp_addr3}),
               32'({qcmd[k].a1, qcmd[k].a2, qcmd[k].a3}));
      end
      @(negedge clk);
      check("drain_idle_busy", 32'(busy), 32'd0);
      check("drain_idle_wr", 32'(bus.dp_wr), 32'd0);
      check("drain_cnt", 32'(issued_cnt), 32'd4);

      // Reset during COMMIT with two queued commands and a push pending
      push(qcmd[0]);
      push(qcmd[1]);
      push(qcmd[2]);
      check("rc_commit_wr", 32'(bus.dp_wr), 32'd1);
      check("rc_commit_done", 32'(done), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rc_dp_wr", 32'(bus.dp_wr), 32'd0);
      check("rc_done", 32'(done), 32'd0);
      check("rc_busy", 32'(busy), 32'd0);
      check("rc_ready", 32'(bus.cmd_ready), 32'd1);
      check("rc_cnt", 32'(issued_cnt), 32'd0);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("rc_after_busy", 32'(busy), 32'd0);

      // Counter wrap
      force dut.issued_cnt_q = '1;
      @(negedge clk);
      release dut.issued_cnt_q;
      @(negedge clk);
      check("wrap_preload", 32'(issued_cnt), 32'hFFFF);
      push(vecs[0].cmd);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wrap_commit_cnt", 32'(issued_cnt), 32'hFFFF);
      @(negedge clk);
      check("wrap_cnt", 32'(issued_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter FIFO_DEPTH, 4, command queue depth; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, 16, width of issued_cnt.
REQ-003 There SHALL be one clock and one reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 cmd_valid in 1: command offered; cmd_ready out 1: queue can accept.
REQ-005 cmd_op in 3: ALU operation code; cmd_a1, cmd_a2, cmd_a3 in 2 each: source A, source B and destination register.
REQ-006 cmd_wr in 1: write result; cmd_trap in 1: halt instead of writing on overflow.
REQ-007 dp_wr out 1, dp_alu_ctl out 3, dp_addr1/dp_addr2/dp_addr3 out 2 each: drive datapath wr/ALUControl/addr1-3.
REQ-008 dp_zero in 1, dp_ovf in 1: datapath Zero/Overflow.
REQ-009 busy out 1, done out 1, halted out 1, clr_halt in 1, zero_flag out 1, ovf_flag out 1, ovf_sticky out 1, issued_cnt out CNT_W.

Function
REQ-010 Command push SHALL occur on a rising edge with cmd_valid & cmd_ready; cmd_ready = !full, from registered occupancy only.
REQ-011 A cmd_valid asserted while the queue is full SHALL be ignored, with no change to queue contents.
REQ-012 FSM states SHALL be IDLE, EXEC, COMMIT and HALT.
REQ-013 IDLE with a non-empty queue SHALL pop the head into a command register and go to EXEC; IDLE with an empty queue SHALL stay in IDLE.
REQ-014 In EXEC, dp_alu_ctl/dp_addr1-3 SHALL equal the command register and dp_wr SHALL be 0.
REQ-015 At the end of EXEC, dp_zero and dp_ovf SHALL be captured into zero_flag and ovf_flag, and ovf_sticky SHALL be set if dp_ovf = 1.
REQ-016 At the end of EXEC, cmd_trap & dp_ovf SHALL send the FSM to HALT; otherwise it SHALL go to COMMIT.
REQ-017 In COMMIT, dp_wr = cmd_wr for exactly one cycle, addresses and ALU control SHALL be held, done = 1, and issued_cnt SHALL increment modulo 2^CNT_W.
REQ-018 From COMMIT, a non-empty queue SHALL pop the next command and go to EXEC (2 cycles/command sustained); otherwise the FSM SHALL go to IDLE.
REQ-019 Latency: a command pushed at edge k into an empty queue while in IDLE SHALL be in EXEC in cycle k+2 and COMMIT in cycle k+3.
REQ-020 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 In HALT: halted = 1, dp_wr = 0, no pops, the trapped command is dropped and not counted, and pushes continue while not full.
REQ-022 clr_halt in HALT SHALL go to IDLE and leave the queue intact; clr_halt in any other state SHALL be ignored.
REQ-023 busy SHALL be 1 in any state other than IDLE, or whenever the queue is non-empty.
REQ-024 dp_wr SHALL never be asserted outside COMMIT.

Reset
REQ-025 rst SHALL have priority over every other input, including a simultaneous push or clr_halt.
REQ-026 rst SHALL flush the queue, set state IDLE, and clear all outputs and flags, including ovf_sticky and issued_cnt.
REQ-027 rst during COMMIT SHALL force dp_wr to 0 from the next cycle; the in-flight command is lost.
REQ-028 cmd_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-029 A shared package datapath_pkg SHALL hold the ALU op codes (ADD=000, SUB=001, others as defined by ALU32), the FSM state enum and a command struct {op, a1, a2, a3, wr, trap}.
REQ-030 The queue SHALL be a sub-module cmd_fifo (synchronous, FIFO_DEPTH entries, full/empty/count outputs); datapath_seq SHALL contain the FSM, command register, flags and counter.

Verification
REQ-031 Push {ADD, a1=3, a2=3, a3=1, wr=1} at edge 0 -> EXEC in cycle 2 with dp_addr=3/3/1 and dp_wr=0; COMMIT in cycle 3 with dp_wr=1 and done=1; issued_cnt=1.
REQ-032 Four back-to-back pushes (FIFO_DEPTH=4, FSM stalled in HALT) -> cmd_ready=0 after the 4th; a 5th push is ignored; after clr_halt, 4 COMMITs occur 2 cycles apart.
REQ-033 {SUB, 1, 1, 1, trap=1} with dp_ovf stubbed to 1 -> HALT, halted=1, no dp_wr pulse, issued_cnt unchanged, ovf_sticky=1.
REQ-034 dp_zero=1 during EXEC of {SUB, 1, 1, 1} -> zero_flag=1 from the COMMIT cycle.
REQ-035 rst asserted in a COMMIT cycle with 2 queued commands -> next cycle dp_wr=0, state IDLE, empty queue, issued_cnt=0.
REQ-036 Preload issued_cnt to 2^CNT_W-1 by forcing, then commit one command -> issued_cnt=0.
